// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch time-set path.
// Holds the edit FSM encoding, field codes and the wrap-around step helper.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET_HH = 3'd1,
        ST_SET_MM = 3'd2,
        ST_SET_SS = 3'd3,
        ST_COMMIT = 3'd4
    } sw_state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HH   = 2'd1;
    localparam logic [1:0] FIELD_MM   = 2'd2;
    localparam logic [1:0] FIELD_SS   = 2'd3;

    localparam logic [7:0] HH_MAX = 8'd99;
    localparam logic [7:0] MS_MAX = 8'd59;

    // One wrap-around step; an out-of-range captured value snaps to 0 either way.
    function automatic logic [7:0] step_field(input logic [7:0] v,
                                              input logic [7:0] max_v,
                                              input logic       up);
        logic [7:0] r;
        if (up)             r = (v >= max_v) ? 8'd0 : v + 8'd1;
        else if (v > max_v) r = 8'd0;
        else if (v == 8'd0) r = max_v;
        else                r = v - 8'd1;
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-FF synchronizer, tick-based debouncer,
// one-clk press pulse on the debounced rising edge, optional auto-repeat.
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int HOLD_TICKS     = 500,
    parameter int REPEAT_TICKS   = 100,
    parameter bit REPEAT_EN      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    output logic press
);

    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

    logic          sync1, sync2;
    logic          level, level_q;
    logic [DW-1:0] deb_cnt;
    logic          rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_q <= level;
            // Only a run of disagreeing tick samples moves the debounced level.
            if (tick) begin
                if (sync2 != level) begin
                    if (deb_cnt == DW'(DEBOUNCE_TICKS - 1)) begin
                        level   <= sync2;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end else begin
                    deb_cnt <= '0;
                end
            end
        end
    end

    assign rise = level & ~level_q;

    if (REPEAT_EN) begin : g_repeat
        localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
        localparam int HW   = $clog2(HMAX + 1);

        logic [HW-1:0] hold_cnt;
        logic          repeating;
        logic          rpt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_cnt  <= '0;
                repeating <= 1'b0;
                rpt       <= 1'b0;
            end else begin
                rpt <= 1'b0;
                if (!level) begin
                    hold_cnt  <= '0;
                    repeating <= 1'b0;
                end else if (tick) begin
                    // First interval is the hold delay, later ones the repeat period.
                    if (hold_cnt == (repeating ? HW'(REPEAT_TICKS - 1) : HW'(HOLD_TICKS - 1))) begin
                        hold_cnt  <= '0;
                        repeating <= 1'b1;
                        rpt       <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
            end
        end

        assign press = rise | rpt;
    end else begin : g_no_repeat
        assign press = rise;
    end

endmodule

// File: rtl/stopwatch_set_ctrl.sv
// Time-set controller: debounced mode/up/down buttons drive an HH/MM/SS edit FSM
// that produces edited values, a one-clk load strobe and blink control.
module stopwatch_set_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int HOLD_TICKS     = 500,
    parameter int REPEAT_TICKS   = 100,
    parameter int BLINK_TICKS    = 250,
    parameter int TIMEOUT_TICKS  = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1khz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [7:0] cur_hours,
    input  logic [7:0] cur_minutes,
    input  logic [7:0] cur_seconds,
    output logic [7:0] set_hours,
    output logic [7:0] set_minutes,
    output logic [7:0] set_seconds,
    output logic       load,
    output logic       set_active,
    output logic [1:0] field,
    output logic       blink_en,
    output logic       blink_phase,
    output sw_state_t  state_dbg
);

    localparam int IW = $clog2(TIMEOUT_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    logic          mode_p, up_p, down_p;
    logic          mode_ev, up_ev, dn_ev, step_ev, any_ev;
    logic          in_set, nxt_set, timeout;
    sw_state_t     state, state_nxt;
    logic [IW-1:0] idle_cnt;
    logic [BW-1:0] blink_cnt;

    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .HOLD_TICKS(HOLD_TICKS),
                   .REPEAT_TICKS(REPEAT_TICKS), .REPEAT_EN(1'b0))
        u_mode (.clk(clk), .rst_n(rst_n), .tick(tick_1khz), .btn(btn_mode), .press(mode_p));

    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .HOLD_TICKS(HOLD_TICKS),
                   .REPEAT_TICKS(REPEAT_TICKS), .REPEAT_EN(1'b1))
        u_up (.clk(clk), .rst_n(rst_n), .tick(tick_1khz), .btn(btn_up), .press(up_p));

    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .HOLD_TICKS(HOLD_TICKS),
                   .REPEAT_TICKS(REPEAT_TICKS), .REPEAT_EN(1'b1))
        u_down (.clk(clk), .rst_n(rst_n), .tick(tick_1khz), .btn(btn_down), .press(down_p));

    // Mode beats up/down; a simultaneous up+down cancels out.
    assign mode_ev = mode_p;
    assign up_ev   = up_p & ~down_p & ~mode_p;
    assign dn_ev   = down_p & ~up_p & ~mode_p;

    assign in_set  = (state == ST_SET_HH) || (state == ST_SET_MM) || (state == ST_SET_SS);
    assign step_ev = in_set & (up_ev | dn_ev);
    assign any_ev  = (in_set & mode_ev) | step_ev;
    assign timeout = in_set & tick_1khz & ~any_ev & (idle_cnt == IW'(TIMEOUT_TICKS - 1));
    assign nxt_set = (state_nxt == ST_SET_HH) || (state_nxt == ST_SET_MM) || (state_nxt == ST_SET_SS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (mode_ev) state_nxt = ST_SET_HH;
            ST_SET_HH: if (mode_ev) state_nxt = ST_SET_MM; else if (timeout) state_nxt = ST_IDLE;
            ST_SET_MM: if (mode_ev) state_nxt = ST_SET_SS; else if (timeout) state_nxt = ST_IDLE;
            ST_SET_SS: if (mode_ev) state_nxt = ST_COMMIT; else if (timeout) state_nxt = ST_IDLE;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        field      = FIELD_NONE;
        set_active = 1'b0;
        blink_en   = 1'b0;
        load       = 1'b0;
        case (state)
            ST_SET_HH: begin field = FIELD_HH; set_active = 1'b1; blink_en = 1'b1; end
            ST_SET_MM: begin field = FIELD_MM; set_active = 1'b1; blink_en = 1'b1; end
            ST_SET_SS: begin field = FIELD_SS; set_active = 1'b1; blink_en = 1'b1; end
            ST_COMMIT: load = 1'b1;
            default:   ;
        endcase
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_hours   <= 8'd0;
            set_minutes <= 8'd0;
            set_seconds <= 8'd0;
            idle_cnt    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (state == ST_IDLE && mode_ev) begin
                set_hours   <= cur_hours;
                set_minutes <= cur_minutes;
                set_seconds <= cur_seconds;
            end else if (step_ev) begin
                case (state)
                    ST_SET_HH: set_hours   <= step_field(set_hours,   HH_MAX, up_ev);
                    ST_SET_MM: set_minutes <= step_field(set_minutes, MS_MAX, up_ev);
                    ST_SET_SS: set_seconds <= step_field(set_seconds, MS_MAX, up_ev);
                    default:   ;
                endcase
            end

            if (!in_set || any_ev)  idle_cnt <= '0;
            else if (tick_1khz)     idle_cnt <= idle_cnt + IW'(1);

            // Entry, field change and every step restart the blink in the visible phase.
            if (!nxt_set) begin
                blink_phase <= 1'b0;
                blink_cnt   <= '0;
            end else if (state_nxt != state || step_ev) begin
                blink_phase <= 1'b1;
                blink_cnt   <= '0;
            end else if (tick_1khz) begin
                if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                    blink_phase <= ~blink_phase;
                    blink_cnt   <= '0;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_set_ctrl.sv
// Directed bench for stopwatch_set_ctrl: debounce, edit FSM, wrap, auto-repeat,
// simultaneity, timeout and asynchronous reset, with hand-computed expectations.
module tb_stopwatch_set_ctrl;
    import stopwatch_pkg::*;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1khz = 1'b0;
    logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [7:0] cur_hours = 8'd0, cur_minutes = 8'd0, cur_seconds = 8'd0;
    logic [7:0] set_hours, set_minutes, set_seconds;
    logic       load, set_active, blink_en, blink_phase;
    logic [1:0] field;
    sw_state_t  state_dbg;

    int errors = 0;
    int checks = 0;
    int load_cnt = 0;
    int exp_loads = 0;

    stopwatch_set_ctrl #(.DEBOUNCE_TICKS(DEB), .HOLD_TICKS(500), .REPEAT_TICKS(100),
                         .BLINK_TICKS(250), .TIMEOUT_TICKS(10000)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1khz(tick_1khz),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
        .load(load), .set_active(set_active), .field(field),
        .blink_en(blink_en), .blink_phase(blink_phase), .state_dbg(state_dbg)
    );

    // clock / tick / reset
    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (2) @(posedge clk);
            #1 tick_1khz = 1'b1;
            @(posedge clk);
            #1 tick_1khz = 1'b0;
        end
    end

    always @(posedge clk) if (load === 1'b1) load_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (tick_1khz !== 1'b1);
        end
    endtask

    task automatic press(input logic m, input logic u, input logic d);
        @(posedge clk);
        #1 btn_mode = m; btn_up = u; btn_down = d;
        wait_ticks(DEB + 3);
        #1 btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        wait_ticks(DEB + 3);
        @(negedge clk);
    endtask

    task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        cur_hours = h; cur_minutes = m; cur_seconds = s;
    endtask

    // scenarios
    task automatic test_reset;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({set_hours, set_minutes, set_seconds, load, set_active, field, blink_en, blink_phase} !== 30'd0
            || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_outputs: got %0d:%0d:%0d ld=%b act=%b fld=%0d be=%b bp=%b st=%0d, expected all 0 / IDLE",
                     set_hours, set_minutes, set_seconds, load, set_active, field, blink_en, blink_phase, state_dbg);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_enter_edit;
        set_cur(8'd12, 8'd34, 8'd56);
        press(1, 0, 0);
        checks++;
        if ({field, set_active, blink_en, blink_phase} !== {FIELD_HH, 3'b111}
            || {set_hours, set_minutes, set_seconds} !== {8'd12, 8'd34, 8'd56}) begin
            errors++;
            $display("FAIL enter_edit: got fld=%0d act=%b be=%b bp=%b %0d:%0d:%0d, expected fld=1 1 1 1 12:34:56",
                     field, set_active, blink_en, blink_phase, set_hours, set_minutes, set_seconds);
        end
        wait_ticks(365);
        @(negedge clk);
        checks++;
        if (blink_phase !== 1'b0 || blink_en !== 1'b1) begin
            errors++;
            $display("FAIL blink_blank: got be=%b bp=%b, expected be=1 bp=0", blink_en, blink_phase);
        end
        wait_ticks(250);
        @(negedge clk);
        checks++;
        if (blink_phase !== 1'b1) begin
            errors++;
            $display("FAIL blink_show: got bp=%b, expected 1", blink_phase);
        end
        press(1, 0, 0);
        checks++;
        if (field !== FIELD_MM) begin
            errors++; $display("FAIL field_mm: got %0d, expected 2", field);
        end
        press(1, 0, 0);
        checks++;
        if (field !== FIELD_SS) begin
            errors++; $display("FAIL field_ss: got %0d, expected 3", field);
        end
        press(1, 0, 0);
        exp_loads++;
        checks++;
        if (load_cnt !== exp_loads || field !== FIELD_NONE || state_dbg !== ST_IDLE || blink_en !== 1'b0) begin
            errors++;
            $display("FAIL commit: got loads=%0d fld=%0d st=%0d be=%b, expected loads=%0d fld=0 IDLE be=0",
                     load_cnt, field, state_dbg, blink_en, exp_loads);
        end
    endtask

    task automatic test_wrap;
        set_cur(8'd0, 8'd59, 8'd30);
        press(1, 0, 0);
        press(0, 0, 1);
        checks++;
        if ({set_hours, set_minutes, set_seconds} !== {8'd99, 8'd59, 8'd30}) begin
            errors++;
            $display("FAIL wrap_hh_down: got %0d:%0d:%0d, expected 99:59:30", set_hours, set_minutes, set_seconds);
        end
        press(1, 0, 0);
        press(0, 1, 0);
        checks++;
        if ({set_hours, set_minutes, set_seconds} !== {8'd99, 8'd0, 8'd30}) begin
            errors++;
            $display("FAIL wrap_mm_up: got %0d:%0d:%0d, expected 99:0:30", set_hours, set_minutes, set_seconds);
        end
        press(0, 0, 1);
        checks++;
        if ({set_hours, set_minutes, set_seconds} !== {8'd99, 8'd59, 8'd30} || blink_phase !== 1'b1) begin
            errors++;
            $display("FAIL wrap_mm_down: got %0d:%0d:%0d bp=%b, expected 99:59:30 bp=1",
                     set_hours, set_minutes, set_seconds, blink_phase);
        end
        press(1, 0, 0);
        press(1, 0, 0);
        exp_loads++;
    endtask

    task automatic test_out_of_range;
        set_cur(8'd3, 8'd75, 8'd9);
        press(1, 0, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        checks++;
        if ({set_hours, set_minutes, set_seconds} !== {8'd3, 8'd0, 8'd9}) begin
            errors++;
            $display("FAIL out_of_range: got %0d:%0d:%0d, expected 3:0:9", set_hours, set_minutes, set_seconds);
        end
        press(1, 0, 0);
        press(1, 0, 0);
        exp_loads++;
    endtask

    task automatic test_auto_repeat;
        set_cur(8'd0, 8'd0, 8'd10);
        press(1, 0, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        @(posedge clk);
        #1 btn_up = 1'b1;
        wait_ticks(554);
        @(negedge clk);
        checks++;
        if (set_seconds !== 8'd12) begin
            errors++; $display("FAIL repeat_mid: got %0d, expected 12", set_seconds);
        end
        wait_ticks(196);
        #1 btn_up = 1'b0;
        wait_ticks(10);
        @(negedge clk);
        checks++;
        if (set_seconds !== 8'd14 || field !== FIELD_SS || load_cnt !== exp_loads) begin
            errors++;
            $display("FAIL repeat_end: got ss=%0d fld=%0d loads=%0d, expected ss=14 fld=3 loads=%0d",
                     set_seconds, field, load_cnt, exp_loads);
        end
        press(1, 0, 0);
        exp_loads++;
    endtask

    task automatic test_simultaneous_and_timeout;
        set_cur(8'd1, 8'd2, 8'd3);
        press(1, 0, 0);
        press(1, 0, 0);
        press(0, 1, 1);
        checks++;
        if ({set_hours, set_minutes, set_seconds} !== {8'd1, 8'd2, 8'd3} || field !== FIELD_MM) begin
            errors++;
            $display("FAIL up_and_down: got %0d:%0d:%0d fld=%0d, expected 1:2:3 fld=2",
                     set_hours, set_minutes, set_seconds, field);
        end
        press(1, 1, 0);
        checks++;
        if ({set_hours, set_minutes, set_seconds} !== {8'd1, 8'd2, 8'd3} || field !== FIELD_SS) begin
            errors++;
            $display("FAIL mode_and_up: got %0d:%0d:%0d fld=%0d, expected 1:2:3 fld=3",
                     set_hours, set_minutes, set_seconds, field);
        end
        wait_ticks(9980);
        @(negedge clk);
        checks++;
        if (field !== FIELD_SS) begin
            errors++; $display("FAIL timeout_early: got fld=%0d, expected 3", field);
        end
        wait_ticks(30);
        @(negedge clk);
        checks++;
        if (state_dbg !== ST_IDLE || field !== FIELD_NONE || load_cnt !== exp_loads
            || {set_hours, set_minutes, set_seconds} !== {8'd1, 8'd2, 8'd3} || blink_phase !== 1'b0) begin
            errors++;
            $display("FAIL timeout: got st=%0d fld=%0d loads=%0d %0d:%0d:%0d bp=%b, expected IDLE 0 loads=%0d 1:2:3 bp=0",
                     state_dbg, field, load_cnt, set_hours, set_minutes, set_seconds, blink_phase, exp_loads);
        end
    endtask

    task automatic test_reset_mid_edit;
        set_cur(8'd5, 8'd6, 8'd7);
        press(1, 0, 0);
        press(1, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({set_hours, set_minutes, set_seconds, load, set_active, field, blink_en, blink_phase} !== 30'd0) begin
            errors++;
            $display("FAIL async_reset: got %0d:%0d:%0d ld=%b act=%b fld=%0d be=%b bp=%b, expected all 0",
                     set_hours, set_minutes, set_seconds, load, set_active, field, blink_en, blink_phase);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ticks(10);
        @(negedge clk);
        checks++;
        if (state_dbg !== ST_IDLE || load_cnt !== exp_loads || set_active !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got st=%0d loads=%0d act=%b, expected IDLE loads=%0d act=0",
                     state_dbg, load_cnt, set_active, exp_loads);
        end
    endtask

    task automatic test_bounce;
        set_cur(8'd0, 8'd0, 8'd20);
        press(1, 0, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        wait_ticks(1);
        for (int i = 0; i < 10; i++) begin
            #1 btn_up = ~btn_up;
            wait_ticks(1);
        end
        @(negedge clk);
        checks++;
        if (set_seconds !== 8'd20) begin
            errors++; $display("FAIL bounce_quiet: got %0d, expected 20", set_seconds);
        end
        @(posedge clk);
        while (tick_1khz !== 1'b1) @(posedge clk);
        #1 btn_up = 1'b1;
        wait_ticks(DEB - 1);
        @(negedge clk);
        checks++;
        if (set_seconds !== 8'd20) begin
            errors++; $display("FAIL bounce_early: got %0d, expected 20", set_seconds);
        end
        wait_ticks(2);
        @(negedge clk);
        checks++;
        if (set_seconds !== 8'd21) begin
            errors++; $display("FAIL bounce_press: got %0d, expected 21", set_seconds);
        end
        #1 btn_up = 1'b0;
        wait_ticks(10);
        @(negedge clk);
        checks++;
        if (set_seconds !== 8'd21) begin
            errors++; $display("FAIL release_no_event: got %0d, expected 21", set_seconds);
        end
        press(1, 0, 0);
        exp_loads++;
        checks++;
        if (load_cnt !== exp_loads || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL final_commit: got loads=%0d st=%0d, expected loads=%0d IDLE", load_cnt, state_dbg, exp_loads);
        end
    endtask

    // sequence and final report
    initial begin
        test_reset;
        test_enter_edit;
        test_wrap;
        test_out_of_range;
        test_auto_repeat;
        test_simultaneous_and_timeout;
        test_reset_mid_edit;
        test_bounce;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
